// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write arbiter that shares one FIFO write port among NUM_REQ
// producers. One producer is granted at a time, for a burst of up to BURST_LEN
// beats. A beat is written only while the FIFO reports wr_ready.
//
// Ports:
//   clk        - single clock, all state on posedge
//   reset      - synchronous, active-high reset
//   req_val    - per-requester data valid
//   req_data   - packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  - per-requester accept (only the granted requester, gated by wr_ready)
//   wr_en      - FIFO write enable
//   wr_data    - FIFO write data
//   wr_ready   - FIFO not-full
//   grant_id   - currently granted requester (meaningful while busy=1)
//   busy       - high while a grant is active
//   beat_total - (FIFO_ARB_STATS_EN only) saturating 16-bit beat count per
//                requester, requester i at [i*16 +: 16]
//
// Optional feature macro: FIFO_ARB_STATS_EN adds the beat_total counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_val,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         beat_total
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BURST_LEN + 1);

  localparam logic [IDW:0]   NUM_REQ_W = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   grant_id_reg, grant_id_next;
  logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]    beat_cnt_reg, beat_cnt_next;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDW-1:0]        cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]    cand_val;
  logic [IDW-1:0]        pick_idx;

  // Candidate k is requester (rr_ptr + k) mod NUM_REQ, so candidate 0 is the
  // highest-priority one for the next arbitration.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDW:0] sum;
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sum          = {1'b0, rr_ptr_reg} + (IDW + 1)'(gi);
      assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IDW'(sum - NUM_REQ_W) : sum[IDW-1:0];
      assign cand_val[gi] = req_val[cand_idx[gi]];
    end
  endgenerate

  // Lowest-numbered valid candidate wins; scan downward so it is written last.
  always_comb begin
    pick_idx = rr_ptr_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_val[k]) begin
        pick_idx = cand_idx[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    req_ready     = '0;
    wr_en         = 1'b0;
    wr_data       = '0;
    busy          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req_val) begin
          grant_id_next = pick_idx;
          beat_cnt_next = '0;
          state_next    = GRANT;
        end
      end

      GRANT: begin
        busy                    = 1'b1;
        req_ready[grant_id_reg] = wr_ready;
        wr_en                   = req_val[grant_id_reg] && wr_ready;
        wr_data                 = data_arr[grant_id_reg];
        // A producer dropping valid ends the burst immediately; otherwise the
        // burst ends on the beat that reaches BURST_LEN. A stall (wr_ready=0
        // with valid high) matches neither branch and simply holds.
        if (!req_val[grant_id_reg] || (wr_en && (beat_cnt_reg == LAST_BEAT))) begin
          state_next    = IDLE;
          beat_cnt_next = '0;
          rr_ptr_next   = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + 1'b1;
        end else if (wr_en) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign grant_id = grant_id_reg;

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (wr_en && (grant_id_reg == IDW'(gi)) && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign beat_total[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed scenarios followed by a randomized phase. Every cycle the DUT
// outputs are compared with a transaction-level reference model (current
// owner, next search start, beats in burst) kept in plain integers.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_val;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic              wr_ready;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0]   beat_total;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_total(beat_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Producers: remaining beats, next data word, temporary valid suppression.
  int           prod_left [N];
  logic [DW-1:0] prod_data [N];
  bit           hold_off  [N];

  // Reference model.
  int m_owner;   // -1 when no grant
  int m_next;    // first requester searched at the next arbitration
  int m_beats;   // beats written in the current burst
  int m_total [N];

  // Logs for directed checks.
  int wr_log_data[$];
  int wr_log_cyc[$];
  int grant_log[$];
  int grant_cyc_log[$];
  int cyc;
  bit prev_busy;
  bit checking;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log_data.delete();
    wr_log_cyc.delete();
    grant_log.delete();
    grant_cyc_log.delete();
    cyc = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_val[i] = (prod_left[i] > 0) && !hold_off[i];
      req_data[i*DW +: DW] = prod_data[i];
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic         e_busy;
    e_ready = '0;
    e_wr    = 1'b0;
    e_busy  = (m_owner >= 0);
    if (e_busy) begin
      e_ready[m_owner] = wr_ready;
      e_wr             = req_val[m_owner] && wr_ready;
    end
    chk("busy", busy, e_busy);
    chk("wr_en", wr_en, e_wr);
    chk("req_ready", req_ready, e_ready);
    if (e_busy) chk("grant_id", grant_id, m_owner);
    if (e_wr)   chk("wr_data", wr_data, prod_data[m_owner]);
  endtask

  task automatic model_release(input int g);
    m_next  = (g + 1) % N;
    m_owner = -1;
    m_beats = 0;
  endtask

  task automatic model_update();
    if (reset) begin
      m_owner = -1;
      m_next  = 0;
      m_beats = 0;
      for (int i = 0; i < N; i++) m_total[i] = 0;
    end else if (m_owner < 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_val[(m_next + k) % N]) m_owner = (m_next + k) % N;
      end
      m_beats = 0;
    end else begin
      int g;
      g = m_owner;
      if (!req_val[g]) begin
        model_release(g);
      end else if (wr_ready) begin
        m_beats++;
        if (m_total[g] < 65535) m_total[g]++;
        if (m_beats == BL) model_release(g);
      end
    end
  endtask

  // One clock cycle: drive, sample on the falling edge, advance model and
  // producers, then step past the rising edge.
  task automatic cycle();
    drive();
    @(negedge clk);
    cyc++;
    if (checking) check_outputs();
    if (wr_en) begin
      wr_log_data.push_back(int'(wr_data));
      wr_log_cyc.push_back(cyc);
      $display("write cyc=%0d id=%0d data=%02h", cyc, grant_id, wr_data);
    end
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(grant_id));
      grant_cyc_log.push_back(cyc);
    end
    prev_busy = busy;
    for (int i = 0; i < N; i++) begin
      if (req_val[i] && req_ready[i]) begin
        prod_data[i] = prod_data[i] + 8'd1;
        prod_left[i] = prod_left[i] - 1;
      end
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic idle_producers();
    for (int i = 0; i < N; i++) begin
      prod_left[i] = 0;
      hold_off[i]  = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    wr_ready = 1'b1;
    req_val  = '0;
    req_data = '0;
    checking = 1'b0;
    prev_busy = 1'b0;
    m_owner = -1;
    m_next  = 0;
    m_beats = 0;
    for (int i = 0; i < N; i++) begin
      prod_data[i] = '0;
      m_total[i]   = 0;
    end
    idle_producers();
    cycle();
    cycle();
    reset    = 1'b0;
    checking = 1'b1;

    // Reset state.
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_wr_data", wr_data, 8'h00);

    // Scenario 1: only requester 2, six beats.
    clear_logs();
    prod_data[2] = 8'h10;
    prod_left[2] = 6;
    repeat (11) cycle();
    chk("s1_nwrites", wr_log_data.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("s1_data%0d", k), wr_log_data[k], 32'h10 + k);
    end
    chk("s1_wcyc0", wr_log_cyc[0], 2);
    chk("s1_wcyc3", wr_log_cyc[3], 5);
    chk("s1_wcyc4", wr_log_cyc[4], 7);
    chk("s1_ngrants", grant_log.size(), 2);
    chk("s1_grant0", grant_log[0], 2);
    chk("s1_grant1", grant_log[1], 2);
    chk("s1_gcyc0", grant_cyc_log[0], 2);
    chk("s1_gcyc1", grant_cyc_log[1], 7);

    // Scenario 2: all four requesters continuously valid.
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) begin
      prod_left[i] = 1000;
      prod_data[i] = 8'(i * 64);
    end
    repeat (25) cycle();
    chk("s2_nwrites", wr_log_data.size(), 20);
    chk("s2_ngrants", grant_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("s2_grant%0d", k), grant_log[k], k % N);
      chk($sformatf("s2_gcyc%0d", k), grant_cyc_log[k], 2 + 5 * k);
    end
    idle_producers();

    // Scenario 3: stall for three cycles after beat 2 of requester 1.
    do_reset();
    clear_logs();
    prod_left[1] = 4;
    prod_data[1] = 8'h30;
    wr_ready = 1'b1;
    repeat (3) cycle();
    wr_ready = 1'b0;
    repeat (3) cycle();
    wr_ready = 1'b1;
    repeat (3) cycle();
    chk("s3_nwrites", wr_log_data.size(), 4);
    chk("s3_wcyc1", wr_log_cyc[1], 3);
    chk("s3_wcyc2", wr_log_cyc[2], 7);
    chk("s3_wcyc3", wr_log_cyc[3], 8);
    chk("s3_data3", wr_log_data[3], 32'h33);
    chk("s3_ngrants", grant_log.size(), 1);
    chk("s3_busy_end", busy, 1'b0);

    // Scenario 4: requester 0 drops after two beats, requester 3 next.
    do_reset();
    clear_logs();
    prod_left[0] = 2;
    prod_data[0] = 8'h50;
    prod_left[3] = 4;
    prod_data[3] = 8'h60;
    repeat (10) cycle();
    chk("s4_ngrants", grant_log.size(), 2);
    chk("s4_grant0", grant_log[0], 0);
    chk("s4_grant1", grant_log[1], 3);
    chk("s4_nwrites", wr_log_data.size(), 6);
    chk("s4_data1", wr_log_data[1], 32'h51);
    chk("s4_data2", wr_log_data[2], 32'h60);
    idle_producers();

    // Scenario 5: reset during beat 2 of a burst to requester 1.
    do_reset();
    clear_logs();
    prod_left[1] = 10;
    prod_data[1] = 8'h70;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("s5_busy", busy, 1'b0);
    chk("s5_wr_en", wr_en, 1'b0);
    chk("s5_req_ready", req_ready, 4'b0000);
    clear_logs();
    for (int i = 0; i < N; i++) prod_left[i] = 1000;
    repeat (2) cycle();
    chk("s5_first_grant", grant_log[0], 0);
    idle_producers();

`ifdef FIFO_ARB_STATS_EN
    // Scenario 6: three full rotations, then reset clears the counters.
    do_reset();
    for (int i = 0; i < N; i++) prod_left[i] = 1000;
    repeat (60) cycle();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("s6_total%0d", i), beat_total[i*16 +: 16], 16'd12);
    end
    do_reset();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("s6_clear%0d", i), beat_total[i*16 +: 16], 16'd0);
    end
    idle_producers();
`endif

    // Randomized phase against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (prod_left[i] == 0 && ($urandom % 4) == 0) prod_left[i] = $urandom_range(1, 8);
        hold_off[i] = (($urandom % 6) == 0);
      end
      wr_ready = (($urandom % 4) != 0);
      reset    = (($urandom % 150) == 0);
      cycle();
    end
    reset = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rand_total%0d", i), beat_total[i*16 +: 16], 16'(m_total[i]));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
